game_controller: RTL and testbench
==================================

// Module: game_controller
// PURPOSE
//   Registered game-flow FSM for the pong system. Consumes one-pulse button events, the per-frame
//   refresh_tick and the ball block's scoring events. Produces game_state for the top-level RGB mux,
//   game_active for the ball block, ball_speed, and the serve countdown digit for the text overlay.
// PARAMETERS
//   SPEED_MIN        1    lowest selectable ball speed
//   SPEED_MAX        8    highest selectable ball speed
//   SPEED_DEFAULT    3    ball_speed after reset
//   SERVE_FRAMES     60   refresh_ticks per countdown digit (3,2,1)
//   WIN_SCORE        9    score at or above which a game ends
//   OVER_HOLD_FRAMES 120  refresh_ticks during which OVER ignores start_pulse
// PORTS
//   clk           in   1  pixel clock (25 MHz); all logic on its rising edge
//   reset         in   1  synchronous, active-high
//   refresh_tick  in   1  1-cycle pulse once per frame
//   start_pulse   in   1  1-cycle debounced start/pause button event
//   setting_pulse in   1  1-cycle debounced settings button event
//   up_pulse      in   1  1-cycle speed-increment event (SETTINGS only)
//   down_pulse    in   1  1-cycle speed-decrement event (SETTINGS only)
//   point_scored  in   1  1-cycle pulse from ball; score1/score2 already updated in that cycle
//   score1        in   4  player-1 score
//   score2        in   4  player-2 score
//   game_state    out  3  0 MENU, 1 SETTINGS, 2 SERVE, 3 PLAY, 4 PAUSE, 5 OVER
//   game_active   out  1  1 only in PLAY (ball moves)
//   ball_speed    out  4  current speed, SPEED_MIN..SPEED_MAX
//   serve_count   out  2  countdown digit in SERVE (3..1); 0 in all other states
//   winner        out  2  0 none, 1 player 1, 2 player 2; valid in OVER
// BEHAVIOUR
//   Reset: game_state=MENU, game_active=0, ball_speed=SPEED_DEFAULT, serve_count=0, winner=0,
//     frame counter=0. Reset has priority over every other input at any time, including mid-SERVE
//     or mid-OVER hold.
//   All outputs are registered or decoded from registered state. An input event in cycle N is visible
//     on the outputs after edge N+1. game_active = (game_state==PLAY).
//   MENU: start_pulse -> SERVE. Otherwise setting_pulse -> SETTINGS. start wins when both fire.
//   SETTINGS: up_pulse -> speed+1, saturating at SPEED_MAX. down_pulse -> speed-1, saturating at
//     SPEED_MIN. Both in the same cycle -> no change. setting_pulse -> MENU. start_pulse is ignored.
//     Speed persists across games and changes only in SETTINGS or on reset.
//   Entering SERVE: serve_count=3, frame counter=0. Each refresh_tick increments the frame counter.
//     When the counter reaches SERVE_FRAMES it clears and serve_count decrements.
//     The decrement from 1 instead transitions to PLAY, with serve_count=0.
//     Total SERVE duration = 3*SERVE_FRAMES ticks. Other pulses are ignored.
//   PLAY: start_pulse -> PAUSE. On point_scored:
//     - if score1>=WIN_SCORE -> OVER, winner=1;
//     - else if score2>=WIN_SCORE -> OVER, winner=2;
//     - else -> SERVE, restarting the countdown at 3.
//     point_scored has priority over a simultaneous start_pulse.
//   PAUSE: start_pulse -> PLAY. The frame counter is frozen. point_scored is ignored.
//   Entering OVER: frame counter=0. Each refresh_tick counts up, saturating at OVER_HOLD_FRAMES.
//     start_pulse is accepted only after the count has reached OVER_HOLD_FRAMES; it then goes to MENU
//     and clears winner to 0. Earlier start_pulses are dropped, not queued.
//   Pulses arriving in a state that does not use them have no effect.
//   Undefined state codes 6 and 7 recover to MENU on the next edge.
//   Frame counter: 8 bits, sized for the largest of SERVE_FRAMES and OVER_HOLD_FRAMES. It never wraps.
// TESTING
//   1. Reset, then one start_pulse -> game_state=2 and serve_count=3 the next cycle.
//      After 180 refresh_ticks -> game_state=3, game_active=1, serve_count=0.
//   2. Enter SETTINGS and give 10 up_pulses -> ball_speed=8 (saturates).
//      Then 10 down_pulses -> 1. Simultaneous up+down -> unchanged.
//      setting_pulse -> MENU with speed retained.
//   3. PLAY with score1=4, point_scored -> SERVE with serve_count=3.
//      PLAY with score2=9, point_scored -> OVER with winner=2.
//   4. In PLAY, start_pulse -> PAUSE. 50 ticks, then start_pulse -> PLAY.
//      point_scored during PAUSE -> no change.
//   5. In OVER, start_pulse at tick 100 -> stays OVER. start_pulse at tick 120 -> MENU with winner=0.
//   6. Assert reset mid-SERVE (serve_count=2) with ball_speed=6 -> MENU, serve_count=0,
//      ball_speed=3, game_active=0.

Source files
------------

// File: rtl/game_controller_if.sv
// rtl/game_controller_if.sv - button/scoring event inputs and game-flow outputs of the pong controller
interface game_controller_if;
    logic       refresh_tick;
    logic       start_pulse;
    logic       setting_pulse;
    logic       up_pulse;
    logic       down_pulse;
    logic       point_scored;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [2:0] game_state;
    logic       game_active;
    logic [3:0] ball_speed;
    logic [1:0] serve_count;
    logic [1:0] winner;

    // Driver of events and consumer of the game-flow outputs.
    modport master (
        output refresh_tick, start_pulse, setting_pulse, up_pulse, down_pulse,
        output point_scored, score1, score2,
        input  game_state, game_active, ball_speed, serve_count, winner
    );

    // The controller itself.
    modport slave (
        input  refresh_tick, start_pulse, setting_pulse, up_pulse, down_pulse,
        input  point_scored, score1, score2,
        output game_state, game_active, ball_speed, serve_count, winner
    );
endinterface

// File: rtl/game_controller.sv
// rtl/game_controller.sv - registered game-flow FSM for pong (menu, settings, serve countdown, play, pause, game over)
module game_controller #(
    parameter int SPEED_MIN        = 1,
    parameter int SPEED_MAX        = 8,
    parameter int SPEED_DEFAULT    = 3,
    parameter int SERVE_FRAMES     = 60,
    parameter int WIN_SCORE        = 9,
    parameter int OVER_HOLD_FRAMES = 120
) (
    input  logic              clk,
    input  logic              reset,
    game_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        MENU     = 3'd0,
        SETTINGS = 3'd1,
        SERVE    = 3'd2,
        PLAY     = 3'd3,
        PAUSE    = 3'd4,
        OVER     = 3'd5
    } state_t;

    localparam logic [3:0] SPD_MIN   = 4'(SPEED_MIN);
    localparam logic [3:0] SPD_MAX   = 4'(SPEED_MAX);
    localparam logic [3:0] SPD_DEF   = 4'(SPEED_DEFAULT);
    localparam logic [3:0] WIN_LIM   = 4'(WIN_SCORE);
    // Last frame index of one countdown digit; the tick on it rolls the digit.
    localparam logic [7:0] SERVE_END = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] HOLD_END  = 8'(OVER_HOLD_FRAMES);

    state_t     state_q, state_d;
    logic [3:0] speed_q, speed_d;
    logic [1:0] serve_count_q, serve_count_d;
    logic [1:0] winner_q, winner_d;
    logic [7:0] frame_q, frame_d;

    // Next-state and next-register computation for the game flow.
    always_comb begin
        state_d       = state_q;
        speed_d       = speed_q;
        serve_count_d = serve_count_q;
        winner_d      = winner_q;
        frame_d       = frame_q;

        case (state_q)
            MENU: begin
                if (bus.start_pulse) begin
                    state_d       = SERVE;
                    serve_count_d = 2'd3;
                    frame_d       = 8'd0;
                end else if (bus.setting_pulse) begin
                    state_d = SETTINGS;
                end
            end

            SETTINGS: begin
                // Simultaneous up and down cancel out.
                if (bus.up_pulse && !bus.down_pulse && speed_q < SPD_MAX) begin
                    speed_d = speed_q + 4'd1;
                end else if (bus.down_pulse && !bus.up_pulse && speed_q > SPD_MIN) begin
                    speed_d = speed_q - 4'd1;
                end
                if (bus.setting_pulse) begin
                    state_d = MENU;
                end
            end

            SERVE: begin
                if (bus.refresh_tick) begin
                    if (frame_q >= SERVE_END) begin
                        frame_d = 8'd0;
                        if (serve_count_q <= 2'd1) begin
                            state_d       = PLAY;
                            serve_count_d = 2'd0;
                        end else begin
                            serve_count_d = serve_count_q - 2'd1;
                        end
                    end else begin
                        frame_d = frame_q + 8'd1;
                    end
                end
            end

            PLAY: begin
                // A scored point outranks a pause request in the same cycle.
                if (bus.point_scored) begin
                    frame_d = 8'd0;
                    if (bus.score1 >= WIN_LIM) begin
                        state_d  = OVER;
                        winner_d = 2'd1;
                    end else if (bus.score2 >= WIN_LIM) begin
                        state_d  = OVER;
                        winner_d = 2'd2;
                    end else begin
                        state_d       = SERVE;
                        serve_count_d = 2'd3;
                    end
                end else if (bus.start_pulse) begin
                    state_d = PAUSE;
                end
            end

            PAUSE: begin
                if (bus.start_pulse) begin
                    state_d = PLAY;
                end
            end

            OVER: begin
                if (bus.refresh_tick && frame_q < HOLD_END) begin
                    frame_d = frame_q + 8'd1;
                end
                // Start is honoured only once the hold period has fully elapsed.
                if (bus.start_pulse && frame_q >= HOLD_END) begin
                    state_d  = MENU;
                    winner_d = 2'd0;
                    frame_d  = 8'd0;
                end
            end

            default: begin
                state_d       = MENU;
                serve_count_d = 2'd0;
                winner_d      = 2'd0;
                frame_d       = 8'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= MENU;
            speed_q       <= SPD_DEF;
            serve_count_q <= 2'd0;
            winner_q      <= 2'd0;
            frame_q       <= 8'd0;
        end else begin
            state_q       <= state_d;
            speed_q       <= speed_d;
            serve_count_q <= serve_count_d;
            winner_q      <= winner_d;
            frame_q       <= frame_d;
        end
    end

    assign bus.game_state  = state_q;
    assign bus.game_active = (state_q == PLAY);
    assign bus.ball_speed  = speed_q;
    assign bus.serve_count = serve_count_q;
    assign bus.winner      = winner_q;

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - scoreboard bench for game_controller
module tb_game_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic [11:0] val;
    } exp_t;

    exp_t exp_q[$];

    game_controller_if ifc ();

    game_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare the DUT outputs against the oldest due expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            logic [11:0] act;
            e = exp_q.pop_front();
            act = {ifc.game_state, ifc.game_active, ifc.ball_speed, ifc.serve_count, ifc.winner};
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got state=%0d active=%0d speed=%0d serve=%0d winner=%0d, want state=%0d active=%0d speed=%0d serve=%0d winner=%0d",
                         e.name, act[11:9], act[8], act[7:4], act[3:2], act[1:0],
                         e.val[11:9], e.val[8], e.val[7:4], e.val[3:2], e.val[1:0]);
            end
        end
    end

    task automatic expect_out(input string name, input logic [2:0] st, input logic [3:0] spd,
                              input logic [1:0] sc, input logic [1:0] w);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.val  = {st, (st == 3'd3), spd, sc, w};
        exp_q.push_back(e);
    endtask

    task automatic pulse(input logic st, input logic se, input logic up, input logic dn, input logic pt);
        ifc.start_pulse   = st;
        ifc.setting_pulse = se;
        ifc.up_pulse      = up;
        ifc.down_pulse    = dn;
        ifc.point_scored  = pt;
        @(posedge clk);
        #1;
        ifc.start_pulse   = 1'b0;
        ifc.setting_pulse = 1'b0;
        ifc.up_pulse      = 1'b0;
        ifc.down_pulse    = 1'b0;
        ifc.point_scored  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.refresh_tick = 1'b1;
            @(posedge clk);
            #1;
            ifc.refresh_tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "timeout");
    end

    initial begin
        ifc.refresh_tick  = 1'b0;
        ifc.start_pulse   = 1'b0;
        ifc.setting_pulse = 1'b0;
        ifc.up_pulse      = 1'b0;
        ifc.down_pulse    = 1'b0;
        ifc.point_scored  = 1'b0;
        ifc.score1        = 4'd0;
        ifc.score2        = 4'd0;

        do_reset();
        expect_out("reset", 3'd0, 4'd3, 2'd0, 2'd0);
        pulse(0, 0, 1, 0, 0);
        expect_out("menu_up_ignored", 3'd0, 4'd3, 2'd0, 2'd0);

        // Full serve countdown, then player 1 wins
        pulse(1, 0, 0, 0, 0);
        expect_out("start_to_serve", 3'd2, 4'd3, 2'd3, 2'd0);
        ticks(59);
        expect_out("serve_59_ticks", 3'd2, 4'd3, 2'd3, 2'd0);
        ticks(1);
        expect_out("serve_60_ticks", 3'd2, 4'd3, 2'd2, 2'd0);
        ticks(119);
        expect_out("serve_179_ticks", 3'd2, 4'd3, 2'd1, 2'd0);
        ticks(1);
        expect_out("serve_180_play", 3'd3, 4'd3, 2'd0, 2'd0);
        ifc.score1 = 4'd9;
        pulse(0, 0, 0, 0, 1);
        expect_out("p1_wins", 3'd5, 4'd3, 2'd0, 2'd1);
        ticks(120);
        pulse(1, 0, 0, 0, 0);
        expect_out("over_to_menu_p1", 3'd0, 4'd3, 2'd0, 2'd0);

        // Pause handling
        ifc.score1 = 4'd0;
        pulse(1, 0, 0, 0, 0);
        ticks(180);
        expect_out("second_serve_play", 3'd3, 4'd3, 2'd0, 2'd0);
        pulse(1, 0, 0, 0, 0);
        expect_out("play_to_pause", 3'd4, 4'd3, 2'd0, 2'd0);
        ticks(50);
        expect_out("pause_50_ticks", 3'd4, 4'd3, 2'd0, 2'd0);
        ifc.score1 = 4'd9;
        pulse(0, 0, 0, 0, 1);
        expect_out("pause_point_ignored", 3'd4, 4'd3, 2'd0, 2'd0);
        pulse(1, 0, 0, 0, 0);
        expect_out("pause_to_play", 3'd3, 4'd3, 2'd0, 2'd0);

        // Scoring: non-winning point beats simultaneous start, then player 2 wins
        ifc.score1 = 4'd4;
        ifc.score2 = 4'd0;
        pulse(1, 0, 0, 0, 1);
        expect_out("point_to_serve", 3'd2, 4'd3, 2'd3, 2'd0);
        ticks(180);
        expect_out("reserve_play", 3'd3, 4'd3, 2'd0, 2'd0);
        ifc.score2 = 4'd9;
        pulse(0, 0, 0, 0, 1);
        expect_out("p2_wins", 3'd5, 4'd3, 2'd0, 2'd2);
        ticks(100);
        pulse(1, 0, 0, 0, 0);
        expect_out("over_start_early", 3'd5, 4'd3, 2'd0, 2'd2);
        ticks(20);
        pulse(1, 0, 0, 0, 0);
        expect_out("over_start_120", 3'd0, 4'd3, 2'd0, 2'd0);
        ifc.score1 = 4'd0;
        ifc.score2 = 4'd0;

        // Settings
        pulse(0, 1, 0, 0, 0);
        expect_out("menu_to_settings", 3'd1, 4'd3, 2'd0, 2'd0);
        pulse(1, 0, 0, 0, 0);
        expect_out("settings_start_ignored", 3'd1, 4'd3, 2'd0, 2'd0);
        for (int i = 0; i < 10; i++) pulse(0, 0, 1, 0, 0);
        expect_out("speed_sat_max", 3'd1, 4'd8, 2'd0, 2'd0);
        for (int i = 0; i < 10; i++) pulse(0, 0, 0, 1, 0);
        expect_out("speed_sat_min", 3'd1, 4'd1, 2'd0, 2'd0);
        pulse(0, 0, 1, 1, 0);
        expect_out("up_down_min", 3'd1, 4'd1, 2'd0, 2'd0);
        for (int i = 0; i < 5; i++) pulse(0, 0, 1, 0, 0);
        expect_out("speed_six", 3'd1, 4'd6, 2'd0, 2'd0);
        pulse(0, 0, 1, 1, 0);
        expect_out("up_down_six", 3'd1, 4'd6, 2'd0, 2'd0);
        pulse(0, 1, 0, 0, 0);
        expect_out("settings_to_menu", 3'd0, 4'd6, 2'd0, 2'd0);

        // Start beats setting in MENU, then reset mid-serve
        pulse(1, 1, 0, 0, 0);
        expect_out("start_wins_menu", 3'd2, 4'd6, 2'd3, 2'd0);
        ticks(60);
        expect_out("serve_digit2", 3'd2, 4'd6, 2'd2, 2'd0);
        do_reset();
        expect_out("reset_mid_serve", 3'd0, 4'd3, 2'd0, 2'd0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
